// File: rtl/rtu_pkg.sv
// Shared parameters and slot payload for the PST physical-register allocator.
package rtu_pkg;

  localparam int unsigned PREG_NUM   = 64;
  localparam int unsigned PREG_IDX_W = $clog2(PREG_NUM);

  // One pre-allocation slot: a held physical register index.
  typedef struct packed {
    logic                  vld;
    logic [PREG_IDX_W-1:0] idx;
  } preg_slot_t;

endpackage

// File: rtl/rtu_pst_preg_pri_enc.sv
// Lowest-index-first priority encoder over the per-entry DEALLOC flags.
module rtu_pst_preg_pri_enc
  import rtu_pkg::*;
(
  input  logic [PREG_NUM-1:0]   req,
  output logic                  found,
  output logic [PREG_IDX_W-1:0] idx,
  output logic [PREG_NUM-1:0]   onehot
);

  // Scan from the top down so the lowest set bit wins the index.
  always_comb begin
    found  = |req;
    idx    = '0;
    onehot = req & (~req + PREG_NUM'(1));
    for (int i = PREG_NUM - 1; i >= 0; i--) begin
      if (req[i]) idx = PREG_IDX_W'(i);
    end
  end

endmodule

// File: rtl/rtu_pst_preg_alloc.sv
// Physical-register allocator: pre-allocates free pregs into a 2-deep
// ready buffer and grants them to IDU one per cycle.
module rtu_pst_preg_alloc
  import rtu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_clk,
  input  logic [PREG_NUM-1:0]   x_preg_cur_stats_dealloc,
  input  logic                  rtu_global_flush,
  input  logic                  idu_rtu_pst_alloc_req,
  output logic                  rtu_idu_pst_alloc_gnt,
  output logic [PREG_IDX_W-1:0] rtu_idu_pst_alloc_preg,
  output logic                  rtu_idu_pst_alloc_rdy,
  output logic [PREG_NUM-1:0]   x_pre_alloc_vld,
  output logic [PREG_NUM-1:0]   x_alloc_vld,
  output logic [1:0]            rtu_pst_alloc_slot_cnt
);

  preg_slot_t slot0_q, slot1_q;
  preg_slot_t slot0_d, slot1_d;

  logic                  pick_found;
  logic [PREG_IDX_W-1:0] pick_idx;
  logic [PREG_NUM-1:0]   pick_onehot;
  logic                  gnt;
  logic                  refill;
  logic [1:0]            post_cnt;

  rtu_pst_preg_pri_enc u_pri_enc (
    .req    (x_preg_cur_stats_dealloc),
    .found  (pick_found),
    .idx    (pick_idx),
    .onehot (pick_onehot)
  );

  // Grant and refill decisions; refill looks at the post-dequeue occupancy.
  assign gnt      = idu_rtu_pst_alloc_req & slot0_q.vld & ~rtu_global_flush;
  assign post_cnt = rtu_pst_alloc_slot_cnt - 2'(gnt);
  assign refill   = ~post_cnt[1] & pick_found & ~rtu_global_flush & ~rst_clk;

  assign rtu_pst_alloc_slot_cnt = 2'(slot0_q.vld) + 2'(slot1_q.vld);
  assign rtu_idu_pst_alloc_gnt  = gnt;
  assign rtu_idu_pst_alloc_preg = slot0_q.idx;
  assign rtu_idu_pst_alloc_rdy  = slot0_q.vld;
  assign x_pre_alloc_vld        = pick_onehot & {PREG_NUM{refill}};
  assign x_alloc_vld            = (PREG_NUM'(1) << slot0_q.idx) & {PREG_NUM{gnt}};

  // Dequeue shifts slot1 forward, then the pick fills the first empty slot.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (gnt) begin
      slot0_d = slot1_q;
      slot1_d = '0;
    end
    if (refill) begin
      if (!slot0_d.vld) slot0_d = '{vld: 1'b1, idx: pick_idx};
      else              slot1_d = '{vld: 1'b1, idx: pick_idx};
    end
    if (rtu_global_flush) begin
      slot0_d = '0;
      slot1_d = '0;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or posedge rst_clk) begin
    if (rst_clk) begin
      slot0_q <= '0;
      slot1_q <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
    end
  end

endmodule
